// File: rtl/ula_b_operand_stage.sv
// Registered ALU-B operand select with a valid/ready output stage and one-entry skid buffer.
// Define ULA_B_ZEXT_EN to give selector 110 a zero-extended immediate; otherwise 110 is illegal.
module ula_b_operand_stage #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 16,
    parameter int INC_VALUE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           selector,
    input  logic [WIDTH-1:0]     Data_0,
    input  logic [WIDTH-1:0]     Data_1,
    input  logic [IMM_WIDTH-1:0] Imm,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     Data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_err
);

    localparam logic [WIDTH-1:0] INC_CONST = WIDTH'(INC_VALUE);

    logic [WIDTH-1:0] imm_sext;
`ifdef ULA_B_ZEXT_EN
    logic [WIDTH-1:0] imm_zext;
`endif
    logic [WIDTH-1:0] dec_data;
    logic             dec_err;

    logic             or_valid, or_err, sr_valid, sr_err, in_ready_r;
    logic [WIDTH-1:0] or_data, sr_data;
    logic             nxt_or_valid, nxt_or_err, nxt_sr_valid, nxt_sr_err;
    logic [WIDTH-1:0] nxt_or_data, nxt_sr_data;

    logic accept;
    logic xfer;

    assign accept = in_valid && in_ready_r;
    assign xfer   = or_valid && out_ready;

    // Illegal codes still produce a beat: value 0 tagged with err.
    always_comb begin
        imm_sext                  = {WIDTH{Imm[IMM_WIDTH-1]}};
        imm_sext[IMM_WIDTH-1:0]   = Imm;
`ifdef ULA_B_ZEXT_EN
        imm_zext                  = '0;
        imm_zext[IMM_WIDTH-1:0]   = Imm;
`endif
        dec_data = '0;
        dec_err  = 1'b0;
        case (selector)
            3'b000:          dec_data = Data_0;
            3'b001:          dec_data = INC_CONST;
            3'b010, 3'b011:  dec_data = Data_1;
            3'b100:          dec_data = imm_sext;
            3'b101:          dec_data = imm_sext << 2;
            3'b110: begin
`ifdef ULA_B_ZEXT_EN
                dec_data = imm_zext;
`else
                dec_err  = 1'b1;
`endif
            end
            default:         dec_err  = 1'b1;
        endcase
    end

    // Accept with transfer and a full skid register is impossible since in_ready is low then.
    always_comb begin
        nxt_or_valid = or_valid;
        nxt_or_data  = or_data;
        nxt_or_err   = or_err;
        nxt_sr_valid = sr_valid;
        nxt_sr_data  = sr_data;
        nxt_sr_err   = sr_err;
        if (xfer) begin
            if (sr_valid) begin
                nxt_or_data  = sr_data;
                nxt_or_err   = sr_err;
                nxt_sr_valid = 1'b0;
            end else begin
                nxt_or_valid = 1'b0;
            end
        end
        if (accept) begin
            if (!sr_valid && (!or_valid || xfer)) begin
                nxt_or_valid = 1'b1;
                nxt_or_data  = dec_data;
                nxt_or_err   = dec_err;
            end else begin
                nxt_sr_valid = 1'b1;
                nxt_sr_data  = dec_data;
                nxt_sr_err   = dec_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            or_valid   <= 1'b0;
            or_data    <= '0;
            or_err     <= 1'b0;
            sr_valid   <= 1'b0;
            sr_data    <= '0;
            sr_err     <= 1'b0;
            in_ready_r <= 1'b0;
        end else begin
            or_valid   <= nxt_or_valid;
            or_data    <= nxt_or_data;
            or_err     <= nxt_or_err;
            sr_valid   <= nxt_sr_valid;
            sr_data    <= nxt_sr_data;
            sr_err     <= nxt_sr_err;
            in_ready_r <= !nxt_sr_valid;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = or_valid;
    assign Data_out  = or_data;
    assign out_err   = or_err;

endmodule

// File: tb/tb_ula_b_operand_stage.sv
// Bench for ula_b_operand_stage: queue-based reference model checked every cycle,
// plus directed literal checks; honours ULA_B_ZEXT_EN for selector 110.
module tb_ula_b_operand_stage;

    typedef struct {
        logic [31:0] v;
        logic        e;
    } beat_t;

    logic        clk;
    logic        reset;
    logic [2:0]  selector;
    logic [31:0] Data_0;
    logic [31:0] Data_1;
    logic [15:0] Imm;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Data_out;
    logic        out_valid;
    logic        out_ready;
    logic        out_err;

    int total = 0;
    int bad   = 0;

    beat_t       q[$];
    logic [31:0] m_data;
    logic        m_err;
    logic        m_rdy;
    bit          model_ok = 0;

    ula_b_operand_stage #(.WIDTH(32), .IMM_WIDTH(16), .INC_VALUE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .selector  (selector),
        .Data_0    (Data_0),
        .Data_1    (Data_1),
        .Imm       (Imm),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Data_out  (Data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand value straight from the selector table using plain integer arithmetic.
    function automatic beat_t ref_operand(input logic [2:0] sel, input logic [31:0] d0,
                                          input logic [31:0] d1, input logic [15:0] imm);
        beat_t  b;
        longint s;
        s = longint'(imm);
        if (imm >= 16'h8000) s = s - 65536;
        b.v = 32'd0;
        b.e = 1'b0;
        case (sel)
            3'd0:       b.v = d0;
            3'd1:       b.v = 32'd4;
            3'd2, 3'd3: b.v = d1;
            3'd4:       b.v = 32'(s);
            3'd5:       b.v = 32'(s * 4);
            3'd6: begin
`ifdef ULA_B_ZEXT_EN
                b.v = 32'(imm);
`else
                b.e = 1'b1;
`endif
            end
            default:    b.e = 1'b1;
        endcase
        return b;
    endfunction

    // Model: at most two beats in flight, FIFO order; output shows the oldest or the last shown.
    always @(posedge clk) begin : model
        bit    acc;
        beat_t nb;
        if (reset) begin
            q.delete();
            m_data   = 32'd0;
            m_err    = 1'b0;
            m_rdy    = 1'b0;
            model_ok = 1'b1;
        end else begin
            acc = in_valid && m_rdy;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) begin
                nb = ref_operand(selector, Data_0, Data_1, Imm);
                q.push_back(nb);
            end
            if (q.size() > 0) begin
                m_data = q[0].v;
                m_err  = q[0].e;
            end
            m_rdy = (q.size() < 2);
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            total++;
            if (out_valid !== (q.size() > 0)) begin
                bad++;
                $display("[TB] FAIL model out_valid: got %0b want %0b at %0t", out_valid, q.size() > 0, $time);
            end
            total++;
            if (in_ready !== m_rdy) begin
                bad++;
                $display("[TB] FAIL model in_ready: got %0b want %0b at %0t", in_ready, m_rdy, $time);
            end
            total++;
            if (Data_out !== m_data) begin
                bad++;
                $display("[TB] FAIL model Data_out: got %h want %h at %0t", Data_out, m_data, $time);
            end
            total++;
            if (out_err !== m_err) begin
                bad++;
                $display("[TB] FAIL model out_err: got %0b want %0b at %0t", out_err, m_err, $time);
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [2:0] sel, input logic [31:0] d0,
                                 input logic [31:0] d1, input logic [15:0] imm, input logic ordy);
        in_valid  = v;
        selector  = sel;
        Data_0    = d0;
        Data_1    = d1;
        Imm       = imm;
        out_ready = ordy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [2:0]  legacy_sel[4]  = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] legacy_exp[4]  = '{32'h11, 32'h4, 32'h22, 32'h22};
    logic [31:0] imm_exp[4];
    logic        imm_err[4];

    initial begin
        imm_exp[0] = 32'hFFFF_FFFE; imm_err[0] = 1'b0;
        imm_exp[1] = 32'hFFFF_FFF8; imm_err[1] = 1'b0;
`ifdef ULA_B_ZEXT_EN
        imm_exp[2] = 32'h0000_FFFE; imm_err[2] = 1'b0;
`else
        imm_exp[2] = 32'h0;         imm_err[2] = 1'b1;
`endif
        imm_exp[3] = 32'h0;         imm_err[3] = 1'b1;

        reset = 1'b1;
        applyStimulus(1'b1, 3'd0, 32'hDEAD, 32'hBEEF, 16'h0, 1'b0);
        @(negedge clk);
        step();
        checkOutput("reset in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset Data_out", Data_out, 32'd0);

        reset = 1'b0;
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 16'h0, 1'b1);
        step();
        checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("post-reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("post-reset Data_out", Data_out, 32'd0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, legacy_sel[i], 32'h11, 32'h22, 16'h0, 1'b1);
            step();
            checkOutput($sformatf("legacy sel%0d data", i), Data_out, legacy_exp[i]);
            checkOutput($sformatf("legacy sel%0d err", i), 32'(out_err), 32'd0);
        end

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'(4 + i), 32'h11, 32'h22, 16'hFFFE, 1'b1);
            step();
            checkOutput($sformatf("imm sel%0d data", 4 + i), Data_out, imm_exp[i]);
            checkOutput($sformatf("imm sel%0d err", 4 + i), 32'(out_err), 32'(imm_err[i]));
        end

        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 16'h0, 1'b1);
        step();
        applyStimulus(1'b1, 3'd0, 32'd1, 32'h0, 16'h0, 1'b0);
        step();
        checkOutput("bp A data", Data_out, 32'd1);
        checkOutput("bp A in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 3'd0, 32'd2, 32'h0, 16'h0, 1'b0);
        step();
        checkOutput("bp B in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp B data held", Data_out, 32'd1);
        applyStimulus(1'b1, 3'd0, 32'd3, 32'h0, 16'h0, 1'b0);
        step();
        checkOutput("bp stall data", Data_out, 32'd1);
        applyStimulus(1'b0, 3'd0, 32'd0, 32'h0, 16'h0, 1'b1);
        step();
        checkOutput("bp release data", Data_out, 32'd2);
        checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp release valid", 32'(out_valid), 32'd1);
        step();
        checkOutput("bp drained valid", 32'(out_valid), 32'd0);
        checkOutput("bp drained data kept", Data_out, 32'd2);

        applyStimulus(1'b1, 3'd0, 32'd5, 32'h0, 16'h0, 1'b0);
        step();
        applyStimulus(1'b1, 3'd0, 32'd6, 32'h0, 16'h0, 1'b0);
        step();
        checkOutput("stall full in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        applyStimulus(1'b1, 3'd0, 32'd7, 32'h0, 16'h0, 1'b1);
        step();
        checkOutput("mid reset valid", 32'(out_valid), 32'd0);
        checkOutput("mid reset data", Data_out, 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'h0, 16'h0, 1'b1);
        step();
        checkOutput("after reset valid", 32'(out_valid), 32'd0);
        checkOutput("after reset in_ready", 32'(in_ready), 32'd1);
        step();
        checkOutput("held beats gone", 32'(out_valid), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            applyStimulus(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                          $urandom(), $urandom(), 16'($urandom()),
                          1'($urandom_range(0, 2) != 0));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
